prng_spi_cmd_ctrl: RTL and testbench

- Command controller directly downstream of the SPI target in the Rule-110 PRNG design.
- Consumes each received 64-bit SPI word as one command: seed load, step the automaton N generations, snapshot the PRNG state, or read status.
- Drives the PRNG core over a seed-load strobe and a step valid/ack handshake.
- Owns the tx word that the SPI target shifts out on the next frame.

---
 rtl/prng_spi_cmd_ctrl.sv | 216 +++++++++++++++++++++
 tb/tb_prng_spi_cmd_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/prng_spi_cmd_ctrl.sv
// Command controller between the SPI target and the Rule-110 PRNG core.
// Each rising edge of i_rx_valid delivers one 64-bit command word.
module prng_spi_cmd_ctrl #(
    parameter int         WIDTH = 64,
    parameter logic [7:0] SIG   = 8'hA5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_rx_data,
    input  logic             i_rx_valid,
    input  logic             i_tx_hold,
    output logic [WIDTH-1:0] o_tx_data,
    output logic [WIDTH-1:0] o_seed,
    output logic             o_seed_load,
    output logic             o_step_req,
    input  logic             i_step_ack,
    input  logic [WIDTH-1:0] i_prng_state,
    output logic             o_busy
);

    localparam logic [7:0] OP_SEED_LO = 8'h01;
    localparam logic [7:0] OP_SEED_HI = 8'h02;
    localparam logic [7:0] OP_STEP    = 8'h03;
    localparam logic [7:0] OP_READ    = 8'h04;
    localparam logic [7:0] OP_STATUS  = 8'h05;

    typedef enum logic [1:0] {IDLE, DECODE, STEP} state_t;

    state_t           state_q, state_d;
    logic             rx_valid_q;
    logic [7:0]       cmd_op_q, cmd_op_d;
    logic [15:0]      cmd_cnt_q, cmd_cnt_d;
    logic [15:0]      count_q, count_d;
    logic             exec_q, exec_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] pend_val_q, pend_val_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic             seed_load_q, seed_load_d;
    logic             step_req_q, step_req_d;
    logic             busy_q, busy_d;
    logic             seeded_q, seeded_d;
    logic             err_opcode_q, err_opcode_d;
    logic             err_overrun_q, err_overrun_d;

    logic             accept;
    logic [7:0]       op_in;
    logic [WIDTH-1:0] status_word;
    logic             tx_wr;
    logic [WIDTH-1:0] tx_val;
    logic             unused_rx_bits;

    // Only some rx bit ranges carry fields; the rest are reserved.
    assign unused_rx_bits = ^i_rx_data;

    assign accept = i_rx_valid & ~rx_valid_q;
    assign op_in  = i_rx_data[WIDTH-1 -: 8];

    always_comb begin
        status_word              = '0;
        status_word[WIDTH-1 -: 8] = SIG;
        status_word[47:32]       = count_q;
        status_word[3]           = busy_q;
        status_word[2]           = err_overrun_q;
        status_word[1]           = err_opcode_q;
        status_word[0]           = seeded_q;
    end

    always_comb begin
        state_d       = state_q;
        cmd_op_d      = cmd_op_q;
        cmd_cnt_d     = cmd_cnt_q;
        count_d       = count_q;
        exec_d        = 1'b0;
        tx_d          = tx_q;
        pend_d        = pend_q;
        pend_val_d    = pend_val_q;
        seed_d        = seed_q;
        seed_load_d   = 1'b0;
        step_req_d    = step_req_q;
        busy_d        = busy_q;
        seeded_d      = seeded_q;
        err_opcode_d  = err_opcode_q;
        err_overrun_d = err_overrun_q;
        tx_wr         = 1'b0;
        tx_val        = status_word;

        // A STATUS accepted during a step run executes one cycle later.
        if (exec_q) begin
            tx_wr         = 1'b1;
            tx_val        = status_word;
            err_opcode_d  = 1'b0;
            err_overrun_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    cmd_op_d  = op_in;
                    cmd_cnt_d = i_rx_data[15:0];
                    state_d   = DECODE;
                    // Seed writes land at accept so the strobe sits in t+1.
                    if (op_in == OP_SEED_LO) begin
                        seed_d[31:0] = i_rx_data[31:0];
                        seed_load_d  = 1'b1;
                        seeded_d     = 1'b1;
                    end else if (op_in == OP_SEED_HI) begin
                        seed_d[WIDTH-1:32] = i_rx_data[WIDTH-33:0];
                    end
                end
            end
            DECODE: begin
                state_d = IDLE;
                case (cmd_op_q)
                    OP_SEED_LO, OP_SEED_HI: ;
                    OP_STEP: begin
                        count_d = cmd_cnt_q;
                        if (cmd_cnt_q != 16'd0) begin
                            state_d    = STEP;
                            step_req_d = 1'b1;
                            busy_d     = 1'b1;
                        end
                    end
                    OP_READ: begin
                        tx_wr  = 1'b1;
                        tx_val = i_prng_state;
                    end
                    OP_STATUS: begin
                        tx_wr         = 1'b1;
                        tx_val        = status_word;
                        err_opcode_d  = 1'b0;
                        err_overrun_d = 1'b0;
                    end
                    default: err_opcode_d = 1'b1;
                endcase
            end
            STEP: begin
                if (accept) begin
                    if (op_in == OP_STATUS) begin
                        exec_d = 1'b1;
                    end else begin
                        err_overrun_d = 1'b1;
                    end
                end
                if (i_step_ack && step_req_q) begin
                    count_d = count_q - 16'd1;
                    if (count_q == 16'd1) begin
                        state_d    = IDLE;
                        step_req_d = 1'b0;
                        busy_d     = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Never change the tx word while the SPI target is sampling it.
        if (tx_wr) begin
            if (i_tx_hold) begin
                pend_d     = 1'b1;
                pend_val_d = tx_val;
            end else begin
                tx_d   = tx_val;
                pend_d = 1'b0;
            end
        end else if (pend_q && !i_tx_hold) begin
            tx_d   = pend_val_q;
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= IDLE;
            rx_valid_q    <= 1'b0;
            cmd_op_q      <= '0;
            cmd_cnt_q     <= '0;
            count_q       <= '0;
            exec_q        <= 1'b0;
            tx_q          <= '0;
            pend_q        <= 1'b0;
            pend_val_q    <= '0;
            seed_q        <= '0;
            seed_load_q   <= 1'b0;
            step_req_q    <= 1'b0;
            busy_q        <= 1'b0;
            seeded_q      <= 1'b0;
            err_opcode_q  <= 1'b0;
            err_overrun_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_valid_q    <= i_rx_valid;
            cmd_op_q      <= cmd_op_d;
            cmd_cnt_q     <= cmd_cnt_d;
            count_q       <= count_d;
            exec_q        <= exec_d;
            tx_q          <= tx_d;
            pend_q        <= pend_d;
            pend_val_q    <= pend_val_d;
            seed_q        <= seed_d;
            seed_load_q   <= seed_load_d;
            step_req_q    <= step_req_d;
            busy_q        <= busy_d;
            seeded_q      <= seeded_d;
            err_opcode_q  <= err_opcode_d;
            err_overrun_q <= err_overrun_d;
        end
    end

    assign o_tx_data   = tx_q;
    assign o_seed      = seed_q;
    assign o_seed_load = seed_load_q;
    assign o_step_req  = step_req_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_prng_spi_cmd_ctrl.sv
// Directed bench for prng_spi_cmd_ctrl: seeding, stepping, READ/STATUS, errors, reset.
module tb_prng_spi_cmd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] rx_data;
    logic        rx_valid;
    logic        tx_hold;
    logic [63:0] tx_data;
    logic [63:0] seed;
    logic        seed_load;
    logic        step_req;
    logic        step_ack;
    logic [63:0] prng_state;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cnt;
    int hs;

    always #5 clk = ~clk;

    prng_spi_cmd_ctrl #(.WIDTH(64), .SIG(8'hA5)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .i_tx_hold    (tx_hold),
        .o_tx_data    (tx_data),
        .o_seed       (seed),
        .o_seed_load  (seed_load),
        .o_step_req   (step_req),
        .i_step_ack   (step_ack),
        .i_prng_state (prng_state),
        .o_busy       (busy)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise valid for one cycle; returns in the cycle after the accept edge.
    task automatic pulse_word(input logic [63:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        rx_data    = '0;
        rx_valid   = 1'b0;
        tx_hold    = 1'b0;
        step_ack   = 1'b0;
        prng_state = '0;
        tick();
        tick();
        check("rst_tx", tx_data, 64'h0);
        check("rst_seed", seed, 64'h0);
        check("rst_seed_load", {63'h0, seed_load}, 64'h0);
        check("rst_req", {63'h0, step_req}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        rst_n = 1'b1;
        tick();

        // Seeding
        pulse_word(64'h0200_0000_DEAD_BEEF);
        check("seed_hi_no_strobe", {63'h0, seed_load}, 64'h0);
        tick();
        tick();
        pulse_word(64'h0100_0000_1234_5678);
        check("seed_lo_strobe", {63'h0, seed_load}, 64'h1);
        check("seed_value", seed, 64'hDEAD_BEEF_1234_5678);
        tick();
        check("seed_strobe_one_cycle", {63'h0, seed_load}, 64'h0);
        tick();

        // STEP 5 with ack tied high
        step_ack = 1'b1;
        pulse_word(64'h0300_0000_0000_0005);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (step_req) cnt++;
            if (busy !== step_req) cnt += 100;
        end
        check("step5_req_cycles", cnt, 64'd5);
        check("step5_busy_done", {63'h0, busy}, 64'h0);

        // STEP 0 issues nothing
        pulse_word(64'h0300_0000_0000_0000);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (step_req || busy) cnt++;
        end
        check("step0_no_req", cnt, 64'd0);

        // STEP 3 with sparse acks and a STATUS after the first handshake
        step_ack = 1'b0;
        pulse_word(64'h0300_0000_0000_0003);
        tick();
        check("step3_req_up", {63'h0, step_req}, 64'h1);
        step_ack = 1'b1;
        tick();
        step_ack = 1'b0;
        hs = 1;
        pulse_word(64'h0500_0000_0000_0000);
        tick();
        check("status_mid_step", tx_data, 64'hA500_0002_0000_0009);
        for (int i = 0; i < 40; i++) begin
            step_ack = (i % 4 == 3);
            if (step_req && step_ack) hs++;
            tick();
        end
        step_ack = 1'b0;
        check("step3_handshakes", hs, 64'd3);
        check("step3_req_down", {63'h0, step_req}, 64'h0);

        // READ with tx_hold during the execute cycle, valid held 100 cycles
        prng_state = 64'h0123_4567_89AB_CDEF;
        rx_data    = 64'h0400_0000_0000_0000;
        rx_valid   = 1'b1;
        tick();
        tx_hold = 1'b1;
        tick();
        tx_hold = 1'b0;
        check("read_deferred", tx_data, 64'hA500_0002_0000_0009);
        tick();
        check("read_value", tx_data, 64'h0123_4567_89AB_CDEF);
        prng_state = 64'hFFFF_0000_FFFF_0000;
        repeat (100) tick();
        rx_valid = 1'b0;
        tick();
        check("read_single_exec", tx_data, 64'h0123_4567_89AB_CDEF);

        // Errors: bad opcode, then a command during STEP
        pulse_word(64'h7F00_0000_0000_0000);
        tick();
        tick();
        pulse_word(64'h0300_0000_0000_000A);
        tick();
        check("step10_busy", {63'h0, busy}, 64'h1);
        pulse_word(64'h0100_0000_CAFE_F00D);
        check("overrun_no_strobe", {63'h0, seed_load}, 64'h0);
        tick();
        check("overrun_seed_kept", seed, 64'hDEAD_BEEF_1234_5678);
        pulse_word(64'h0500_0000_0000_0000);
        tick();
        check("status_errs_set", tx_data, 64'hA500_000A_0000_000F);
        pulse_word(64'h0500_0000_0000_0000);
        tick();
        check("status_errs_clear", tx_data, 64'hA500_000A_0000_0009);

        // Asynchronous reset mid-sequence
        check("pre_reset_req", {63'h0, step_req}, 64'h1);
        rst_n = 1'b0;
        #2;
        check("rst_async_req", {63'h0, step_req}, 64'h0);
        check("rst_async_busy", {63'h0, busy}, 64'h0);
        check("rst_async_tx", tx_data, 64'h0);
        #2;
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (step_req || busy) cnt++;
        end
        check("post_reset_idle", cnt, 64'd0);
        pulse_word(64'h0500_0000_0000_0000);
        tick();
        check("post_reset_status", tx_data, 64'hA500_0000_0000_0000);
        step_ack = 1'b1;
        pulse_word(64'h0300_0000_0000_0002);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (step_req) cnt++;
        end
        check("post_reset_step2", cnt, 64'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
